// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// digits_needed() returns ceil(bin_w*log10(2)) in integer arithmetic.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int ADD3_LIMIT  = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic int digits_needed(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// One BCD digit correction step of the shift-and-add-3 algorithm.
// The add is 4-bit wide; inputs 5..9 map to 8..12, which never carries out.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d_i,
  output logic [BCD_DIGIT_W-1:0] d_o
);

  assign d_o = (d_i >= BCD_DIGIT_W'(ADD3_LIMIT)) ? d_i + BCD_DIGIT_W'(3) : d_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// valid/ready on the input, one-cycle out_valid pulse with packed BCD and per-digit flags.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int THRESH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          out_valid,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic [DIGITS-1:0]             digit_gt,
  output logic                          busy
);

  localparam int ACC_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < digits_needed(BIN_W)) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end
  if (THRESH < 0 || THRESH > 9) begin : g_bad_thresh
    $error("bin2bcd_seq: THRESH must be 0..9");
  end

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   shift_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic [DIGITS-1:0]  gt_d;
  logic [ACC_W-1:0]   bcd_q;
  logic [DIGITS-1:0]  gt_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               last_iter;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .d_i (acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .d_o (acc_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
    assign gt_d[i] = acc_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(THRESH);
  end

  // Top adjusted bit is always zero for legal DIGITS, so truncation loses nothing.
  assign acc_d     = ACC_W'({acc_adj, shift_q[BIN_W-1]});
  assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      gt_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q    <= ST_SHIFT;
            in_ready_q <= 1'b0;
            shift_q    <= bin_in;
            acc_q      <= '0;
            cnt_q      <= '0;
          end
        end
        ST_SHIFT: begin
          acc_q   <= acc_d;
          shift_q <= {shift_q[BIN_W-2:0], 1'b0};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            bcd_q       <= acc_d;
            gt_q        <= gt_d;
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = ~in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign digit_gt  = gt_q;

endmodule
